gate_cmd_initiator: RTL and testbench
=====================================

// Module: gate_cmd_initiator
// PURPOSE
//   Initiator side of the selector/command interface (gl0/gl1, comando, enable -> b, s0..s3).
//   Accepts one request at a time (channel, command) on a valid/ready port.
//   Drives the channel-select and command lines, then pulses enable for a fixed window.
//   Samples the selected channel's result line, waits for busy to drop, and returns a one-cycle response.
// PARAMETERS
//   HOLD_CYCLES  4   cycles enable stays high after b is seen high (1..2^CNT_W-1)
//   TIMEOUT      12  max cycles waiting on b rise (ASSERT) or b fall (RELEASE) (1..2^CNT_W-1)
//   CNT_W        4   width of the shared wait/hold counter
// PORTS
//   clk          in   1  clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   req_valid    in   1  request present
//   req_ready    out  1  initiator can accept a request (high only in IDLE)
//   req_chan     in   2  target channel; bit1 -> gl0, bit0 -> gl1
//   req_cmd      in   1  command value driven on comando
//   gl0          out  1  channel select MSB
//   gl1          out  1  channel select LSB
//   comando      out  1  command line to target
//   enable       out  1  strobe to target
//   b            in   1  busy echo from target
//   s_in         in   4  result lines s3..s0 from target
//   rsp_valid    out  1  one-cycle response strobe
//   rsp_ok       out  1  sampled s_in[chan]; 0 on timeout
//   rsp_timeout  out  1  b handshake timed out
//   rsp_chan     out  2  channel of the completed request
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0 except req_ready=1; latched chan/cmd=0; counter=0.
//   Handshake: request accepted on a clk edge with req_valid&req_ready. chan and cmd are latched.
//     req_ready is 0 from the next cycle until the cycle after rsp_valid.
//   gl0/gl1/comando are registered from the latched values and are stable from SETUP through RESP.
//   FSM (all outputs registered):
//     IDLE    -> SETUP on accept.
//     SETUP   1 cycle with enable=0, so the target mux settles -> ASSERT.
//     ASSERT  enable=1. Counter counts cycles while b=0.
//             b=1 -> HOLD, counter cleared.
//             Counter reaches TIMEOUT -> ABORT.
//     HOLD    enable=1 for exactly HOLD_CYCLES cycles.
//             On the last HOLD cycle, latch ok=s_in[chan] -> RELEASE.
//     RELEASE enable=0. Counter counts while b=1.
//             b=0 -> RESP.
//             Counter reaches TIMEOUT -> ABORT.
//     ABORT   enable=0. Latch ok=0, to=1 -> RESP.
//     RESP    rsp_valid=1 for 1 cycle with rsp_ok, rsp_timeout, rsp_chan -> IDLE.
//             rsp_ok/rsp_timeout/rsp_chan hold their values until the next RESP.
//   Latency with no timeout: accept -> rsp_valid = 1(SETUP) + A(ASSERT, >=1) + HOLD_CYCLES + R(RELEASE, >=1) + 1.
//   Counter saturates and never wraps. TIMEOUT comparisons are equality on the incremented count.
//   A b glitch low during HOLD is ignored; only the ASSERT and RELEASE states watch b.
//   req_valid while busy: ignored, not queued. The requester must hold it.
//   Async reset mid-transaction: immediate return to reset values.
//     enable drops asynchronously, no response is issued, and the in-flight request is lost.
//   s_in bits other than chan are never observed.
// TESTING
//   1 Reset: rst_n=0 mid-HOLD -> enable=0, req_ready=1, rsp_valid=0 immediately; no rsp afterward.
//   2 Nominal: chan=2'b10, cmd=0, target b follows enable after 1 cycle, s_in=4'b0100
//     -> gl0=1, gl1=0, comando=0; enable high 5 cycles; rsp_valid with rsp_ok=1, rsp_chan=2, timeout=0.
//   3 Result low: chan=2'b01, cmd=1, s_in=4'b1101 -> rsp_ok=0, rsp_timeout=0.
//   4 Busy never rises: b=0 always -> enable drops after 12 ASSERT cycles; rsp_timeout=1, rsp_ok=0.
//   5 Busy stuck: b=1 always -> full HOLD, then 12 RELEASE cycles; rsp_timeout=1.
//   6 Back-to-back: req_valid held high with chan 0 then 3
//     -> the second request is accepted only after the first rsp_valid; no overlap of enable windows.

Source files
------------

// File: rtl/gate_cmd_initiator.sv
// Initiator for the gl0/gl1/comando/enable selector interface: one request at a time,
// strobes enable around the target's busy echo and returns a single-cycle response.
module gate_cmd_initiator #(
    parameter int HOLD_CYCLES = 4,
    parameter int TIMEOUT     = 12,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_chan,
    input  logic       req_cmd,
    output logic       gl0,
    output logic       gl1,
    output logic       comando,
    output logic       enable,
    input  logic       b,
    input  logic [3:0] s_in,
    output logic       rsp_valid,
    output logic       rsp_ok,
    output logic       rsp_timeout,
    output logic [1:0] rsp_chan
);

    localparam logic [CNT_W-1:0] HOLD_N = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] TMO_N  = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, SETUP, ASSERT, HOLD, RELEASE, ABORT, RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       chan_q;
    logic             ok_q;

    // Shared wait/hold counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign cnt_inc = sat_inc(cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            chan_q      <= '0;
            ok_q        <= 1'b0;
            req_ready   <= 1'b1;
            gl0         <= 1'b0;
            gl1         <= 1'b0;
            comando     <= 1'b0;
            enable      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_ok      <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_chan    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        chan_q    <= req_chan;
                        gl0       <= req_chan[1];
                        gl1       <= req_chan[0];
                        comando   <= req_cmd;
                        ok_q      <= 1'b0;
                        req_ready <= 1'b0;
                        state     <= SETUP;
                    end
                end
                // Select lines were driven last cycle; give the target mux one quiet cycle.
                SETUP: begin
                    enable <= 1'b1;
                    cnt    <= '0;
                    state  <= ASSERT;
                end
                ASSERT: begin
                    if (b) begin
                        cnt   <= '0;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == TMO_N) begin
                            enable <= 1'b0;
                            state  <= ABORT;
                        end
                    end
                end
                // b is deliberately not watched here, so a glitch low cannot cut the window short.
                HOLD: begin
                    if (cnt_inc == HOLD_N) begin
                        ok_q   <= s_in[chan_q];
                        enable <= 1'b0;
                        cnt    <= '0;
                        state  <= RELEASE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RELEASE: begin
                    if (!b) begin
                        rsp_valid   <= 1'b1;
                        rsp_ok      <= ok_q;
                        rsp_timeout <= 1'b0;
                        rsp_chan    <= chan_q;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == TMO_N) begin
                            state <= ABORT;
                        end
                    end
                end
                ABORT: begin
                    ok_q        <= 1'b0;
                    rsp_valid   <= 1'b1;
                    rsp_ok      <= 1'b0;
                    rsp_timeout <= 1'b1;
                    rsp_chan    <= chan_q;
                    state       <= RESP;
                end
                RESP: begin
                    req_ready <= 1'b1;
                    cnt       <= '0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_cmd_initiator.sv
// Bench for gate_cmd_initiator: a target stand-in drives b, and a timeline model derived
// from the request and the target behaviour predicts every output on every cycle.
module tb_gate_cmd_initiator;

    localparam int HOLD = 4;
    localparam int TMO  = 12;
    localparam int MF = 0;  // target echoes enable on b
    localparam int MZ = 1;  // b never rises
    localparam int MO = 2;  // b stuck high

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_chan = 2'b00;
    logic       req_cmd = 1'b0;
    logic       b = 1'b0;
    logic [3:0] s_in = 4'b0000;
    logic       req_ready, gl0, gl1, comando, enable;
    logic       rsp_valid, rsp_ok, rsp_timeout;
    logic [1:0] rsp_chan;

    int mode = MF;
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    // model state
    logic       m_busy = 1'b0;
    int         m_acc = 0, m_en_last = 0, m_resp_k = 0;
    logic       m_ok = 1'b0, m_to = 1'b0, m_cmd = 1'b0;
    logic [1:0] m_chan = 2'b00, m_gl = 2'b00;
    logic       last_ok = 1'b0, last_to = 1'b0;
    logic [1:0] last_chan = 2'b00;

    // observations of the DUT
    int         n_rsp = 0, en_cnt = 0, obs_lat = 0, rise_cyc = 0;
    logic       en_prev = 1'b0;
    logic       obs_ok = 1'b0, obs_to = 1'b0, obs_cmd = 1'b0;
    logic [1:0] obs_chan = 2'b00, obs_gl = 2'b00;
    int         resp_cyc [16];
    logic [1:0] chan_hist [16];
    logic       ok_hist [16];

    gate_cmd_initiator #(
        .HOLD_CYCLES(HOLD),
        .TIMEOUT    (TMO),
        .CNT_W      (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_chan   (req_chan),
        .req_cmd    (req_cmd),
        .gl0        (gl0),
        .gl1        (gl1),
        .comando    (comando),
        .enable     (enable),
        .b          (b),
        .s_in       (s_in),
        .rsp_valid  (rsp_valid),
        .rsp_ok     (rsp_ok),
        .rsp_timeout(rsp_timeout),
        .rsp_chan   (rsp_chan)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) b = (mode == MF) ? enable : (mode == MO);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin : cmp
        int   k;
        logic e_en, e_rv, e_rdy;
        if (!rst_n) begin
            m_busy = 1'b0; last_ok = 1'b0; last_to = 1'b0; last_chan = 2'b00;
            m_gl = 2'b00; m_cmd = 1'b0;
            chk("rst_enable", 32'(enable), 32'd0);
            chk("rst_req_ready", 32'(req_ready), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_ok", 32'(rsp_ok), 32'd0);
            chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
            chk("rst_rsp_chan", 32'(rsp_chan), 32'd0);
            chk("rst_gl", 32'({gl0, gl1}), 32'd0);
            chk("rst_comando", 32'(comando), 32'd0);
        end else begin
            k     = cyc - m_acc;
            e_en  = m_busy && k >= 2 && k <= m_en_last;
            e_rv  = m_busy && k == m_resp_k;
            e_rdy = !m_busy;
            if (e_rv) begin
                last_ok = m_ok; last_to = m_to; last_chan = m_chan;
            end
            chk("enable", 32'(enable), 32'(e_en));
            chk("req_ready", 32'(req_ready), 32'(e_rdy));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            chk("rsp_ok", 32'(rsp_ok), 32'(last_ok));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(last_to));
            chk("rsp_chan", 32'(rsp_chan), 32'(last_chan));
            chk("gl", 32'({gl0, gl1}), 32'(m_gl));
            chk("comando", 32'(comando), 32'(m_cmd));

            if (enable) en_cnt++;
            if (enable && !en_prev) rise_cyc = cyc;
            if (rsp_valid) begin
                obs_ok = rsp_ok; obs_to = rsp_timeout; obs_chan = rsp_chan;
                obs_gl = {gl0, gl1}; obs_cmd = comando; obs_lat = k;
                resp_cyc[n_rsp % 16]  = cyc;
                chan_hist[n_rsp % 16] = rsp_chan;
                ok_hist[n_rsp % 16]   = rsp_ok;
                n_rsp++;
            end

            if (e_rv) begin
                m_busy = 1'b0;
            end else if (e_rdy && req_valid) begin
                m_busy = 1'b1; m_acc = cyc; m_chan = req_chan; m_gl = req_chan;
                m_cmd = req_cmd; en_cnt = 0;
                if (mode == MZ) begin
                    m_en_last = 1 + TMO;  m_resp_k = 3 + TMO;
                    m_ok = 1'b0; m_to = 1'b1;
                end else if (mode == MO) begin
                    m_en_last = 2 + HOLD; m_resp_k = 4 + HOLD + TMO;
                    m_ok = 1'b0; m_to = 1'b1;
                end else begin
                    m_en_last = 2 + HOLD; m_resp_k = 4 + HOLD;
                    m_ok = s_in[req_chan]; m_to = 1'b0;
                end
            end
        end
        en_prev = enable;
    end

    task automatic wait_ready(input string nm);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
        end
        chk({nm, "_accept"}, 32'(got), 32'd1);
    endtask

    task automatic issue(input string nm, input logic [1:0] ch, input logic cmd,
                         input logic [3:0] s, input int md);
        @(posedge clk); #1;
        mode = md; s_in = s; req_chan = ch; req_cmd = cmd; req_valid = 1'b1;
        wait_ready(nm);
        @(posedge clk); #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string nm, input int n0, input int want);
        for (int i = 0; i < 80 && n_rsp < n0 + want; i++) @(posedge clk);
        chk({nm, "_rsp_count"}, 32'(n_rsp - n0), 32'(want));
    endtask

    initial begin
        int n0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // nominal: chan 2, result bit set
        n0 = n_rsp;
        issue("nom", 2'b10, 1'b0, 4'b0100, MF);
        wait_rsp("nom", n0, 1);
        chk("nom_en_cycles", en_cnt, 32'd5);
        chk("nom_ok", 32'(obs_ok), 32'd1);
        chk("nom_to", 32'(obs_to), 32'd0);
        chk("nom_chan", 32'(obs_chan), 32'd2);
        chk("nom_gl", 32'(obs_gl), 32'b10);
        chk("nom_cmd", 32'(obs_cmd), 32'd0);
        chk("nom_latency", obs_lat, 32'd8);

        // result low: chan 1 of 4'b1101
        n0 = n_rsp;
        issue("low", 2'b01, 1'b1, 4'b1101, MF);
        wait_rsp("low", n0, 1);
        chk("low_ok", 32'(obs_ok), 32'd0);
        chk("low_to", 32'(obs_to), 32'd0);
        chk("low_gl", 32'(obs_gl), 32'b01);
        chk("low_cmd", 32'(obs_cmd), 32'd1);

        // busy never rises
        n0 = n_rsp;
        issue("nob", 2'b11, 1'b0, 4'b1111, MZ);
        wait_rsp("nob", n0, 1);
        chk("nob_en_cycles", en_cnt, 32'd12);
        chk("nob_ok", 32'(obs_ok), 32'd0);
        chk("nob_to", 32'(obs_to), 32'd1);
        chk("nob_latency", obs_lat, 32'd15);

        // busy stuck high
        n0 = n_rsp;
        issue("stk", 2'b00, 1'b1, 4'b0001, MO);
        wait_rsp("stk", n0, 1);
        chk("stk_en_cycles", en_cnt, 32'd5);
        chk("stk_ok", 32'(obs_ok), 32'd0);
        chk("stk_to", 32'(obs_to), 32'd1);
        chk("stk_latency", obs_lat, 32'd20);

        // back-to-back with req_valid held
        @(posedge clk); #1;
        mode = MF; s_in = 4'b0001; req_chan = 2'b00; req_cmd = 1'b0; req_valid = 1'b1;
        n0 = n_rsp;
        wait_ready("b2b_first");
        @(posedge clk); #1 req_chan = 2'b11;
        wait_ready("b2b_second");
        @(posedge clk); #1 req_valid = 1'b0;
        wait_rsp("b2b", n0, 2);
        chk("b2b_chan0", 32'(chan_hist[n0 % 16]), 32'd0);
        chk("b2b_chan1", 32'(chan_hist[(n0 + 1) % 16]), 32'd3);
        chk("b2b_ok0", 32'(ok_hist[n0 % 16]), 32'd1);
        chk("b2b_ok1", 32'(ok_hist[(n0 + 1) % 16]), 32'd0);
        chk("b2b_no_overlap", 32'(rise_cyc > resp_cyc[n0 % 16]), 32'd1);

        // async reset in the middle of HOLD
        n0 = n_rsp;
        issue("rst", 2'b10, 1'b0, 4'b0100, MF);
        repeat (2) @(posedge clk);
        #3;
        chk("rst_pre_enable", 32'(enable), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_enable", 32'(enable), 32'd0);
        chk("rst_async_ready", 32'(req_ready), 32'd1);
        chk("rst_async_rsp", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        chk("rst_no_rsp", 32'(n_rsp - n0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
